vmul_pipe: RTL and testbench
============================

Name: vmul_pipe

Overview:
- Next-generation SIMD integer multiplier / multiply-accumulate unit for the vector execution stage.
- Splits a VLEN_W-wide operand into independent 64-bit slices, each packed as 8/16/32/64-bit elements per SEW.
- Adds over the previous multiplier:
  - Uniform fixed latency for every SEW.
  - valid/ready handshake with backpressure, flush and tag passthrough.
  - The RVV multiply-add family (VMACC, VNMSAC, VMADD, VNMSUB).

Parameters:
- VLEN_W, 64, datapath width in bits; must be a multiple of 64; NSLICE = VLEN_W/64.
- TAG_W, 8, width of the opaque tag carried alongside each operation.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  operation present on inputs.
- ready_o  out  1  unit can accept an operation this cycle.
- flush_i  in  1  kill all in-flight operations.
- instr_type_i  in  instr_type_t  VMUL, VMULH, VMULHU, VMULHSU, VMACC, VNMSAC, VMADD, VNMSUB.
- sew_i  in  sew_t  element width (SEW_8/16/32/64).
- tag_i  in  TAG_W  opaque ID.
- data_vs1_i  in  VLEN_W  source 1.
- data_vs2_i  in  VLEN_W  source 2.
- data_vd_i  in  VLEN_W  old destination value (accumulator / multiplicand).
- valid_o  out  1  result present.
- ready_i  in  1  consumer accepts the result.
- tag_o  out  TAG_W  tag of the presented result.
- data_vd_o  out  VLEN_W  result.

Behaviour:
- Reset: valid_o=0, tag_o=0, data_vd_o=0, all stage valids 0, ready_o=1 out of reset.
- Pipeline: three register stages.
  - S1: sign-conditioned magnitudes, negate flag, addend, control.
  - S2: per-slice 32x32 partial products (four per slice) plus control.
  - S3: final result (output register).
- Latency: an op accepted at edge N is presented with valid_o=1 after edge N+3, for every SEW and op.
- Accept: on valid_i && ready_o. Stall: stall = valid_o && !ready_i; ready_o = !stall.
- While stalled, all stages hold (global freeze); no op is lost, duplicated or reordered.
- Throughput is 1 op/cycle when ready_i=1.
- Flush: flush_i at an edge clears all stage valids and valid_o. A valid_i in the same cycle is dropped. Flush overrides stall. Data registers need not clear.
- Operand selection (per element, mod 2^SEW):
  - VMUL: vs1*vs2, low SEW bits.
  - VMULH: signed x signed, high SEW bits.
  - VMULHU: unsigned x unsigned, high SEW bits.
  - VMULHSU: vs2 signed x vs1 unsigned, high SEW bits.
  - VMACC: vd + vs1*vs2.
  - VNMSAC: vd - vs1*vs2.
  - VMADD: vs1*vd + vs2.
  - VNMSUB: vs2 - vs1*vd.
  - MAC ops are signed, low SEW bits; addend and subtraction wrap modulo 2^SEW.
- Signed method: take magnitudes in S1, multiply unsigned, and conditionally two's-complement negate the 2*SEW product before high/low selection. The most-negative value (e.g. 0x80 at SEW_8) must produce correct results.
- Partial products: 8b products compose into 16b and 32b; 32b partials compose into the 64b product. Each level is built as lo*lo + ((lo*hi + hi*lo) << half) + (hi*hi << width) at full precision with no intermediate truncation.
- Unrecognised instr_type or sew: result 0; the op still flows and valid_o still asserts.
- Slices are fully independent; no carries cross 64-bit slice boundaries.
- Reset mid-operation: all in-flight ops are discarded; outputs return to reset values immediately (asynchronous).

Decomposition:
- drac_pkg (shared):
  - VMUL_LATENCY = 3.
  - Helper predicates is_vmul_high(instr_type_t) and is_vmul_mac(instr_type_t).
  - Reuse the existing instr_type_t and sew_t.
- Sub-module vmul_slice64:
  - Combinational datapath for one 64-bit slice: sign conditioning, 8b/16b/32b/64b partial product trees, negate, select, add.
  - Split at stage boundaries via explicit register inputs/outputs owned by vmul_pipe.
  - Instantiated NSLICE times.
  - The top owns the handshake, control pipeline and tag.

Test Plan:
- SEW_8 VMULH, vs1=vs2=0x8080_8080_8080_8080 -> data_vd_o=0x4040_4040_4040_4040 exactly 3 cycles after accept. With VMULHU -> 0x4040_4040_4040_4040. With VMUL -> 0x0000_0000_0000_0000.
- SEW_16 VMACC, vs1=0x0003 lanes, vs2=0x0005 lanes, vd=0x0007 lanes -> 0x0016 in every lane. VNMSAC with the same operands -> 0xFFF8 in every lane (wrap).
- SEW_32 VNMSUB, vs1=2, vd=3, vs2=10 per lane -> 4. VMADD with the same operands -> 16 per lane.
- SEW_64 VMULHU, vs1=vs2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. VMULH with the same operands -> 0x0. VMULHSU with vs2=-1, vs1=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: issue 5 back-to-back tagged ops (tags 1..5); hold ready_i=0 for 4 cycles starting when tag1 appears.
  - ready_o=0 throughout the hold.
  - Results emerge in order 1..5 with correct values.
  - No duplicates when ready_i toggles each cycle.
- Flush/reset: 3 ops in flight, pulse flush_i together with a new valid_i -> valid_o stays 0 for the next 4 cycles; the next op after flush returns with latency 3. Assert rstn_i low mid-stream -> valid_o, data_vd_o and tag_o go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared types and helpers for the vector multiply pipeline.
// Decode predicates live here so every stage agrees on op classes.
package drac_pkg;

    localparam int VMUL_LATENCY = 3;

    typedef enum logic [3:0] {
        VMUL    = 4'd0,
        VMULH   = 4'd1,
        VMULHU  = 4'd2,
        VMULHSU = 4'd3,
        VMACC   = 4'd4,
        VNMSAC  = 4'd5,
        VMADD   = 4'd6,
        VNMSUB  = 4'd7
    } instr_type_t;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_t;

    typedef struct packed {
        logic ok;
        sew_t sew;
        logic high;
        logic sub;
    } ctrl_t;

    function automatic logic is_vmul_high(input instr_type_t t);
        return t inside {VMULH, VMULHU, VMULHSU};
    endfunction

    function automatic logic is_vmul_mac(input instr_type_t t);
        return t inside {VMACC, VNMSAC, VMADD, VNMSUB};
    endfunction

endpackage

// File: rtl/vmul_slice64.sv
// One independent 64-bit multiplier slice, combinational per stage.
// The enclosing pipe owns every register between the three stages.
module vmul_slice64
    import drac_pkg::*;
(
    input  sew_t         sew0_i,
    input  logic         sa_i,
    input  logic         sb_i,
    input  logic [63:0]  a_i,
    input  logic [63:0]  b_i,
    output logic [63:0]  amag_o,
    output logic [63:0]  bmag_o,
    output logic [7:0]   neg_o,
    input  sew_t         sew1_i,
    input  logic [63:0]  amag_i,
    input  logic [63:0]  bmag_i,
    output logic [255:0] pp_o,
    input  ctrl_t        ctrl2_i,
    input  logic [255:0] pp_i,
    input  logic [7:0]   neg_i,
    input  logic [63:0]  add_i,
    output logic [63:0]  res_o
);

    function automatic logic [15:0] m8(input logic [7:0] a, input logic [7:0] b);
        return 16'(a) * 16'(b);
    endfunction

    function automatic logic [31:0] m16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ll, lh, hl, hh;
        ll = m8(a[7:0], b[7:0]);
        lh = m8(a[7:0], b[15:8]);
        hl = m8(a[15:8], b[7:0]);
        hh = m8(a[15:8], b[15:8]);
        return 32'(ll) + ((32'(lh) + 32'(hl)) << 8) + (32'(hh) << 16);
    endfunction

    function automatic logic [63:0] m32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ll, lh, hl, hh;
        ll = m16(a[15:0], b[15:0]);
        lh = m16(a[15:0], b[31:16]);
        hl = m16(a[31:16], b[15:0]);
        hh = m16(a[31:16], b[31:16]);
        return 64'(ll) + ((64'(lh) + 64'(hl)) << 16) + (64'(hh) << 32);
    endfunction

    int          s1_w;
    logic [63:0] s1_m, s1_hb, s1_ea, s1_eb;
    logic        s1_na, s1_nb;

    // Magnitudes per element; 0x80..0 negates to itself, read as unsigned
    always_comb begin
        amag_o = '0;
        bmag_o = '0;
        neg_o  = '0;
        s1_w   = 8 << sew0_i;
        s1_m   = (64'd1 << s1_w) - 64'd1;
        s1_hb  = 64'd1 << (s1_w - 1);
        s1_ea  = '0;
        s1_eb  = '0;
        s1_na  = 1'b0;
        s1_nb  = 1'b0;
        for (int e = 0; e < 8; e++) begin
            if (e * s1_w < 64) begin
                s1_ea = (a_i >> (e * s1_w)) & s1_m;
                s1_eb = (b_i >> (e * s1_w)) & s1_m;
                s1_na = sa_i && ((s1_ea & s1_hb) != 64'd0);
                s1_nb = sb_i && ((s1_eb & s1_hb) != 64'd0);
                if (s1_na) s1_ea = (~s1_ea + 64'd1) & s1_m;
                if (s1_nb) s1_eb = (~s1_eb + 64'd1) & s1_m;
                amag_o   = amag_o | (s1_ea << (e * s1_w));
                bmag_o   = bmag_o | (s1_eb << (e * s1_w));
                neg_o[e] = s1_na ^ s1_nb;
            end
        end
    end

    always_comb begin
        pp_o = '0;
        unique case (sew1_i)
            SEW_8:
                for (int e = 0; e < 8; e++)
                    pp_o[16*e +: 16] = m8(amag_i[8*e +: 8], bmag_i[8*e +: 8]);
            SEW_16:
                for (int e = 0; e < 4; e++)
                    pp_o[32*e +: 32] = m16(amag_i[16*e +: 16], bmag_i[16*e +: 16]);
            SEW_32:
                for (int e = 0; e < 2; e++)
                    pp_o[64*e +: 64] = m32(amag_i[32*e +: 32], bmag_i[32*e +: 32]);
            SEW_64:
                pp_o = {m32(amag_i[63:32], bmag_i[63:32]),
                        m32(amag_i[63:32], bmag_i[31:0]),
                        m32(amag_i[31:0], bmag_i[63:32]),
                        m32(amag_i[31:0], bmag_i[31:0])};
            default: pp_o = '0;
        endcase
    end

    int           s3_w;
    logic [63:0]  s3_m, s3_sel, s3_ad, s3_r;
    logic [127:0] s3_m2, s3_p;

    always_comb begin
        res_o  = '0;
        s3_w   = 8 << ctrl2_i.sew;
        s3_m   = (64'd1 << s3_w) - 64'd1;
        s3_m2  = (128'd1 << (2 * s3_w)) - 128'd1;
        s3_p   = '0;
        s3_sel = '0;
        s3_ad  = '0;
        s3_r   = '0;
        for (int e = 0; e < 8; e++) begin
            if (ctrl2_i.ok && (e * s3_w < 64)) begin
                if (ctrl2_i.sew == SEW_64)
                    s3_p = 128'(pp_i[63:0])
                         + ((128'(pp_i[127:64]) + 128'(pp_i[191:128])) << 32)
                         + (128'(pp_i[255:192]) << 64);
                else
                    s3_p = 128'(pp_i >> (2 * s3_w * e)) & s3_m2;
                if (neg_i[e]) s3_p = (~s3_p + 128'd1) & s3_m2;
                s3_sel = ctrl2_i.high ? 64'(s3_p >> s3_w) : s3_p[63:0];
                s3_ad  = (add_i >> (e * s3_w)) & s3_m;
                s3_r   = ctrl2_i.sub ? s3_ad - s3_sel : s3_ad + s3_sel;
                res_o  = res_o | ((s3_r & s3_m) << (e * s3_w));
            end
        end
    end

endmodule

// File: rtl/vmul_pipe.sv
// Three-stage SIMD multiply / multiply-add unit with a frozen-on-stall
// valid/ready pipeline, flush and tag passthrough.
module vmul_pipe
    import drac_pkg::*;
#(
    parameter int VLEN_W = 64,
    parameter int TAG_W  = 8
)(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  instr_type_t       instr_type_i,
    input  sew_t              sew_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [VLEN_W-1:0] data_vs1_i,
    input  logic [VLEN_W-1:0] data_vs2_i,
    input  logic [VLEN_W-1:0] data_vd_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [TAG_W-1:0]  tag_o,
    output logic [VLEN_W-1:0] data_vd_o
);

    localparam int NSLICE = VLEN_W / 64;

    ctrl_t             ctrl_d, ctrl1_q, ctrl2_q;
    logic              sa, sb, bvd, stall;
    logic              s1_vld_q, s2_vld_q, out_vld_q;
    logic [TAG_W-1:0]  tag1_q, tag2_q, tag_q;
    logic [VLEN_W-1:0] opb, add_d, add1_q, add2_q, res_d, res_q;

    logic [NSLICE-1:0][63:0]  amag_d, bmag_d, amag_q, bmag_q;
    logic [NSLICE-1:0][7:0]   neg_d, neg1_q, neg2_q;
    logic [NSLICE-1:0][255:0] pp_d, pp_q;

    always_comb begin
        ctrl_d      = '0;
        ctrl_d.ok   = instr_type_i inside {VMUL, VMULH, VMULHU, VMULHSU,
                                           VMACC, VNMSAC, VMADD, VNMSUB};
        ctrl_d.sew  = sew_i;
        ctrl_d.high = is_vmul_high(instr_type_i);
        ctrl_d.sub  = instr_type_i inside {VNMSAC, VNMSUB};
        sa          = instr_type_i == VMULH;
        sb          = instr_type_i inside {VMULH, VMULHSU};
        bvd         = instr_type_i inside {VMADD, VNMSUB};
        opb         = bvd ? data_vd_i : data_vs2_i;
        add_d       = '0;
        if (is_vmul_mac(instr_type_i))
            add_d = bvd ? data_vs2_i : data_vd_i;
    end

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        vmul_slice64 u_slice (
            .sew0_i  (sew_i),
            .sa_i    (sa),
            .sb_i    (sb),
            .a_i     (data_vs1_i[64*i +: 64]),
            .b_i     (opb[64*i +: 64]),
            .amag_o  (amag_d[i]),
            .bmag_o  (bmag_d[i]),
            .neg_o   (neg_d[i]),
            .sew1_i  (ctrl1_q.sew),
            .amag_i  (amag_q[i]),
            .bmag_i  (bmag_q[i]),
            .pp_o    (pp_d[i]),
            .ctrl2_i (ctrl2_q),
            .pp_i    (pp_q[i]),
            .neg_i   (neg2_q[i]),
            .add_i   (add2_q[64*i +: 64]),
            .res_o   (res_d[64*i +: 64])
        );
    end

    assign stall     = out_vld_q && !ready_i;
    assign ready_o   = !stall;
    assign valid_o   = out_vld_q;
    assign tag_o     = tag_q;
    assign data_vd_o = res_q;

    // Flush kills valids even while frozen; payload may keep stale data
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            ctrl1_q   <= '0;
            ctrl2_q   <= '0;
            tag1_q    <= '0;
            tag2_q    <= '0;
            tag_q     <= '0;
            amag_q    <= '0;
            bmag_q    <= '0;
            neg1_q    <= '0;
            neg2_q    <= '0;
            add1_q    <= '0;
            add2_q    <= '0;
            pp_q      <= '0;
            res_q     <= '0;
        end else begin
            if (flush_i) begin
                s1_vld_q  <= 1'b0;
                s2_vld_q  <= 1'b0;
                out_vld_q <= 1'b0;
            end else if (!stall) begin
                s1_vld_q  <= valid_i;
                s2_vld_q  <= s1_vld_q;
                out_vld_q <= s2_vld_q;
            end
            if (!stall) begin
                ctrl1_q <= ctrl_d;
                ctrl2_q <= ctrl1_q;
                tag1_q  <= tag_i;
                tag2_q  <= tag1_q;
                tag_q   <= tag2_q;
                amag_q  <= amag_d;
                bmag_q  <= bmag_d;
                neg1_q  <= neg_d;
                neg2_q  <= neg1_q;
                add1_q  <= add_d;
                add2_q  <= add1_q;
                pp_q    <= pp_d;
                res_q   <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_vmul_pipe.sv
// Directed and randomized check of vmul_pipe against an arithmetic
// per-element reference model and an in-order scoreboard.
module tb_vmul_pipe;
    import drac_pkg::*;

    localparam int VW = 128;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          valid_i = 1'b0, ready_o, flush_i = 1'b0;
    instr_type_t   instr_type_i = VMUL;
    sew_t          sew_i = SEW_8;
    logic [TW-1:0] tag_i = '0;
    logic [VW-1:0] vs1 = '0, vs2 = '0, vd = '0;
    logic          valid_o, ready_i = 1'b1;
    logic [TW-1:0] tag_o;
    logic [VW-1:0] data_vd_o;

    always #5 clk = ~clk;

    vmul_pipe #(.VLEN_W(VW), .TAG_W(TW)) dut (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready_o),
        .flush_i(flush_i), .instr_type_i(instr_type_i), .sew_i(sew_i),
        .tag_i(tag_i), .data_vs1_i(vs1), .data_vs2_i(vs2), .data_vd_i(vd),
        .valid_o(valid_o), .ready_i(ready_i), .tag_o(tag_o),
        .data_vd_o(data_vd_o)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [VW-1:0] data;
        int            acc;
        bit            chk;
    } exp_t;

    exp_t          q[$];
    int            n_vec = 0, n_err = 0, cyc = 0;
    int            hold_left = 0;
    bit            hold_arm = 0, toggle = 0, accepted = 0, nxt_chk = 0;
    logic [VW-1:0] nxt_exp = '0;

    task automatic check(input string nm, input logic [VW-1:0] obs,
                         input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] model(input logic [3:0] op, input logic [1:0] sew,
                                            input logic [VW-1:0] a1, input logic [VW-1:0] a2,
                                            input logic [VW-1:0] ad);
        logic [127:0] r, m, hb, x1, x2, xd, s1, s2, v;
        int w;
        w  = 8 << sew;
        m  = (128'd1 << w) - 128'd1;
        hb = 128'd1 << (w - 1);
        r  = '0;
        for (int e = 0; e < VW / w; e++) begin
            x1 = (a1 >> (e * w)) & m;
            x2 = (a2 >> (e * w)) & m;
            xd = (ad >> (e * w)) & m;
            s1 = ((x1 & hb) != 0) ? (x1 | ~m) : x1;
            s2 = ((x2 & hb) != 0) ? (x2 | ~m) : x2;
            case (op)
                4'd0:    v = x1 * x2;
                4'd1:    v = (s1 * s2) >> w;
                4'd2:    v = (x1 * x2) >> w;
                4'd3:    v = (s2 * x1) >> w;
                4'd4:    v = xd + x1 * x2;
                4'd5:    v = xd - x1 * x2;
                4'd6:    v = x1 * xd + x2;
                4'd7:    v = x2 - x1 * xd;
                default: v = '0;
            endcase
            r = r | ((v & m) << (e * w));
        end
        return r;
    endfunction

    // One clock: sample at negedge, update scoreboard, return at posedge+1
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        accepted = valid_i && ready_o && !flush_i;
        if (hold_left > 0) begin
            check("hold_ready_low", VW'(ready_o), '0);
            hold_left--;
        end
        if (valid_o && ready_i) begin
            check("result_pending", VW'(q.size() != 0), VW'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                check("tag", VW'(tag_o), VW'(e.tag));
                check("data", data_vd_o, e.data);
                if (e.chk) check("latency", VW'(cyc - e.acc), VW'(VMUL_LATENCY));
            end
        end
        if (accepted) q.push_back('{tag_i, nxt_exp, cyc, nxt_chk});
        if (flush_i) q.delete();
        @(posedge clk);
        cyc++;
        #1;
        if (hold_arm && valid_o && tag_o == 8'd1) begin
            hold_left = 4;
            hold_arm  = 0;
        end
        if (toggle) ready_i = ~ready_i;
        else        ready_i = (hold_left == 0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] sew,
                         input logic [VW-1:0] a1, input logic [VW-1:0] a2,
                         input logic [VW-1:0] ad, input logic [TW-1:0] t,
                         input logic [VW-1:0] ex, input bit ck);
        int k = 0;
        valid_i = 1'b1;
        instr_type_i = instr_type_t'(op);
        sew_i = sew_t'(sew);
        vs1 = a1; vs2 = a2; vd = ad; tag_i = t;
        nxt_exp = ex; nxt_chk = ck;
        do begin
            cycle();
            k++;
        end while (!accepted && k < 50);
        valid_i = 1'b0;
        check("issue_accepted", VW'(accepted), VW'(1));
    endtask

    task automatic issue_rand(input logic [TW-1:0] t);
        logic [3:0] op;
        logic [1:0] s;
        logic [VW-1:0] a1, a2, ad;
        op = 4'($urandom_range(0, 8));
        if (op == 4'd8) op = 4'hB;
        s  = 2'($urandom_range(0, 3));
        a1 = {$urandom, $urandom, $urandom, $urandom};
        a2 = {$urandom, $urandom, $urandom, $urandom};
        ad = {$urandom, $urandom, $urandom, $urandom};
        issue(op, s, a1, a2, ad, t, model(op, s, a1, a2, ad), 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && q.size() != 0; k++) cycle();
        check("drain_empty", VW'(q.size()), '0);
    endtask

    logic [VW-1:0] c80, c3, c5, c7, w2, w3, w10, ones;

    initial begin
        c80  = {2{64'h8080_8080_8080_8080}};
        c3   = {8{16'h0003}};
        c5   = {8{16'h0005}};
        c7   = {8{16'h0007}};
        w2   = {4{32'd2}};
        w3   = {4{32'd3}};
        w10  = {4{32'd10}};
        ones = '1;

        #12;
        check("rst_valid_o", VW'(valid_o), '0);
        check("rst_tag_o", VW'(tag_o), '0);
        check("rst_data_o", data_vd_o, '0);
        check("rst_ready_o", VW'(ready_o), VW'(1));
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        issue(4'd1, 2'd0, c80, c80, '0, 8'h10, {2{64'h4040_4040_4040_4040}}, 1);
        issue(4'd2, 2'd0, c80, c80, '0, 8'h11, {2{64'h4040_4040_4040_4040}}, 1);
        issue(4'd0, 2'd0, c80, c80, '0, 8'h12, '0, 1);
        issue(4'd4, 2'd1, c3, c5, c7, 8'h13, {8{16'h0016}}, 1);
        issue(4'd5, 2'd1, c3, c5, c7, 8'h14, {8{16'hFFF8}}, 1);
        issue(4'd7, 2'd2, w2, w10, w3, 8'h15, {4{32'd4}}, 1);
        issue(4'd6, 2'd2, w2, w10, w3, 8'h16, {4{32'd16}}, 1);
        issue(4'd2, 2'd3, ones, ones, '0, 8'h17, {2{64'hFFFF_FFFF_FFFF_FFFE}}, 1);
        issue(4'd1, 2'd3, ones, ones, '0, 8'h18, '0, 1);
        issue(4'd3, 2'd3, ones, ones, '0, 8'h19, ones, 1);
        issue(4'hD, 2'd1, c3, c5, c7, 8'h1A, '0, 1);
        drain();

        hold_arm = 1;
        for (int t = 1; t <= 5; t++) issue_rand(TW'(t));
        drain();
        check("hold_done", VW'(hold_left), '0);

        toggle = 1;
        for (int t = 0; t < 24; t++) issue_rand(TW'(8'h40 + t));
        drain();
        toggle = 0;
        ready_i = 1'b1;

        for (int t = 0; t < 150; t++) issue_rand(TW'(t));
        drain();

        for (int t = 0; t < 3; t++) issue_rand(TW'(8'h80 + t));
        flush_i = 1'b1;
        valid_i = 1'b1;
        tag_i = 8'hEE;
        cycle();
        flush_i = 1'b0;
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("flush_quiet", VW'(valid_o), '0);
        end
        issue(4'd4, 2'd1, c3, c5, c7, 8'h90, {8{16'h0016}}, 1);
        drain();

        issue(4'd2, 2'd0, c80, c80, '0, 8'hA0, {2{64'h4040_4040_4040_4040}}, 0);
        issue(4'd2, 2'd0, c80, c80, '0, 8'hA1, {2{64'h4040_4040_4040_4040}}, 0);
        for (int k = 0; k < 10 && !valid_o; k++) cycle();
        check("pre_reset_valid", VW'(valid_o), VW'(1));
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_valid", VW'(valid_o), '0);
        check("async_rst_data", data_vd_o, '0);
        check("async_rst_tag", VW'(tag_o), '0);
        q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("post_reset_quiet", VW'(valid_o), '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
